// File: rtl/tb_pkg.sv
// Shared definitions for the run controller: state encoding, register map and
// CTRL/STATUS bit positions.
package tb_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int REG_CTRL      = 'h00;
    localparam int REG_STATUS    = 'h04;
    localparam int REG_RUN_LEN   = 'h08;
    localparam int REG_VEC_CNT   = 'h0C;
    localparam int REG_SEED_BASE = 'h40;
    localparam int REG_EVT_BASE  = 'h80;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int CTRL_CONT  = 3;

    localparam int STATUS_BUSY = 2;
    localparam int STATUS_DONE = 3;
    localparam int STATUS_CONT = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tb_run_controller.sv
// Avalon-MM control/status block: seed/run-length registers, run sequencer FSM,
// and saturating vector/event counters for host readback.
//   state  | meaning
//   IDLE   | after reset, nothing run yet
//   LOAD   | one cycle, channels load seeds, VEC_CNT cleared
//   RUN    | stimulus enabled, counters live
//   DONE   | run ended by stop or run length reached
module tb_run_controller
    import tb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       slave_address,
    input  logic                    slave_read,
    input  logic                    slave_write,
    input  logic [WIDTH-1:0]        slave_writedata,
    output logic [WIDTH-1:0]        slave_readdata,
    output logic                    o_seed_load,
    output logic [NUM_CH*WIDTH-1:0] o_seeds,
    output logic                    o_tb_enable,
    output logic                    o_ctr_clear,
    input  logic                    i_vec_valid,
    input  logic [NUM_CH-1:0]       i_event
);

    logic             wr_en, rd_en, aligned, seed_sel, evt_sel;
    logic [3:0]       ch;
    logic             ctrl_wr, start_wr, stop_wr, clear_wr;
    logic [1:0]       state_q, state_d;
    logic             busy, running, cont_q, run_len_hit;
    logic [WIDTH-1:0] run_len_q, vec_cnt, rdata_d, rdata_q;
    logic [WIDTH-1:0] seed_q  [NUM_CH];
    logic [WIDTH-1:0] evt_cnt [NUM_CH];
    logic             seed_load_q, enable_q, ctr_clear_q;
    logic [4:0]       status;

    assign wr_en    = slave_write & ~slave_read;
    assign rd_en    = slave_read & ~slave_write;
    assign aligned  = (slave_address[1:0] == 2'b00);
    assign seed_sel = aligned && (slave_address[ADDR_W-1:6] == (ADDR_W-6)'(REG_SEED_BASE >> 6));
    assign evt_sel  = aligned && (slave_address[ADDR_W-1:6] == (ADDR_W-6)'(REG_EVT_BASE >> 6));
    assign ch       = slave_address[5:2];

    assign ctrl_wr  = wr_en && (slave_address == ADDR_W'(REG_CTRL));
    assign start_wr = ctrl_wr && slave_writedata[CTRL_START];
    assign stop_wr  = ctrl_wr && slave_writedata[CTRL_STOP];
    assign clear_wr = ctrl_wr && slave_writedata[CTRL_CLEAR];

    assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);
    assign running = (state_q == S_RUN);

    // The vector arriving this cycle counts toward the run length.
    assign run_len_hit = ({1'b0, vec_cnt} + {{WIDTH{1'b0}}, i_vec_valid}) == {1'b0, run_len_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_wr && !stop_wr) state_d = S_LOAD;
            S_LOAD: begin
                if (stop_wr || (!cont_q && (run_len_q == '0)))
                    state_d = S_DONE;
                else
                    state_d = S_RUN;
            end
            S_RUN: if (stop_wr || (!cont_q && run_len_hit)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cont_q      <= 1'b0;
            run_len_q   <= '0;
            seed_load_q <= 1'b0;
            enable_q    <= 1'b0;
            ctr_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_load_q <= (state_d == S_LOAD);
            enable_q    <= (state_d == S_RUN);
            ctr_clear_q <= clear_wr;
            if (ctrl_wr)
                cont_q <= slave_writedata[CTRL_CONT];
            if (wr_en && !busy && (slave_address == ADDR_W'(REG_RUN_LEN)))
                run_len_q <= slave_writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) seed_q[i] <= '0;
        end else if (wr_en && seed_sel && !busy) begin
            for (int i = 0; i < NUM_CH; i++)
                if (ch == 4'(i)) seed_q[i] <= slave_writedata;
        end
    end

    sat_counter #(.WIDTH(WIDTH)) u_vec_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (running && i_vec_valid),
        .clr_i   (clear_wr || (state_q == S_LOAD)),
        .cnt_o   (vec_cnt)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sat_counter #(.WIDTH(WIDTH)) u_evt_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc_i   (running && i_event[g]),
            .clr_i   (clear_wr),
            .cnt_o   (evt_cnt[g])
        );
        assign o_seeds[g*WIDTH +: WIDTH] = seed_q[g];
    end

    assign status = {cont_q, (state_q == S_DONE), busy, state_q};

    always_comb begin
        rdata_d = '0;
        if (slave_address == ADDR_W'(REG_STATUS))  rdata_d = {{(WIDTH-5){1'b0}}, status};
        if (slave_address == ADDR_W'(REG_RUN_LEN)) rdata_d = run_len_q;
        if (slave_address == ADDR_W'(REG_VEC_CNT)) rdata_d = vec_cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            if (seed_sel && (ch == 4'(i))) rdata_d = seed_q[i];
            if (evt_sel && (ch == 4'(i)))  rdata_d = evt_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rdata_q <= '0;
        else if (rd_en)
            rdata_q <= rdata_d;
    end

    assign slave_readdata = rdata_q;
    assign o_seed_load    = seed_load_q;
    assign o_tb_enable    = enable_q;
    assign o_ctr_clear    = ctr_clear_q;

endmodule

// File: tb/tb_tb_run_controller.sv
// Bench for tb_run_controller: a 32-bit/4-channel instance for the main scenarios and
// an 8-bit/2-channel instance whose counters are small enough to reach saturation.
module tb_tb_run_controller;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   addr = '0;
    logic         rd = 1'b0, wr = 1'b0, rd2 = 1'b0, wr2 = 1'b0;
    logic [31:0]  wdata = '0, rdata;
    logic [7:0]   wdata2 = '0, rdata2;
    logic         seed_load, en, ctr_clr, seed_load2, en2, ctr_clr2;
    logic [127:0] seeds;
    logic [15:0]  seeds2;
    logic         vv = 1'b0, vv2 = 1'b0;
    logic [3:0]   ev = '0;
    logic [1:0]   ev2 = '0;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    tb_run_controller #(.WIDTH(32), .NUM_CH(4), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .slave_address(addr), .slave_read(rd),
        .slave_write(wr), .slave_writedata(wdata), .slave_readdata(rdata),
        .o_seed_load(seed_load), .o_seeds(seeds), .o_tb_enable(en),
        .o_ctr_clear(ctr_clr), .i_vec_valid(vv), .i_event(ev)
    );

    tb_run_controller #(.WIDTH(8), .NUM_CH(2), .ADDR_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .slave_address(addr), .slave_read(rd2),
        .slave_write(wr2), .slave_writedata(wdata2), .slave_readdata(rdata2),
        .o_seed_load(seed_load2), .o_seeds(seeds2), .o_tb_enable(en2),
        .o_ctr_clear(ctr_clr2), .i_vec_valid(vv2), .i_event(ev2)
    );

    task automatic bw(input bit sel, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wdata2 = d[7:0];
        if (sel) wr2 = 1'b1; else wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; wr2 = 1'b0;
    endtask

    task automatic br(input bit sel, input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        if (sel) rd2 = 1'b1; else rd = 1'b1;
        @(negedge clk);
        rd = 1'b0; rd2 = 1'b0;
        d = sel ? {24'h0, rdata2} : rdata;
    endtask

    task automatic test_reset();
        logic [7:0]  alist [8] = '{8'h04, 8'h0C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h00, 8'h10};
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rdata_in_reset got=%h exp=0", rdata); end
        total++; if ({en, seed_load, ctr_clr} !== 3'b000) begin bad++; $display("FAIL outs_in_reset got=%b exp=000", {en, seed_load, ctr_clr}); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rdata_before_read got=%h exp=0", rdata); end
        for (int i = 0; i < 8; i++) begin
            br(0, alist[i], d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_read addr=%h got=%h exp=0", alist[i], d); end
        end
    endtask

    task automatic test_start_stop_idle();
        logic [31:0] d;
        bw(0, 8'h00, 32'h3);
        total++; if (seed_load !== 1'b0) begin bad++; $display("FAIL startstop_seed_load got=%b exp=0", seed_load); end
        br(0, 8'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL startstop_status got=%h exp=0", d); end
    endtask

    task automatic test_basic_run();
        logic [31:0] d;
        int nsl = 0, nen = 0, sl_at = -1, en_at = -1;
        bw(0, 8'h48, 32'hDEADBEEF);
        br(0, 8'h48, d);
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL seed2_read got=%h exp=deadbeef", d); end
        total++; if (seeds[95:64] !== 32'hDEADBEEF) begin bad++; $display("FAIL seed2_port got=%h exp=deadbeef", seeds[95:64]); end
        bw(0, 8'h08, 32'd5);
        vv = 1'b1;
        bw(0, 8'h00, 32'h1);
        for (int k = 0; k < 12; k++) begin
            if (seed_load) begin nsl++; if (sl_at < 0) sl_at = k; end
            if (en) begin nen++; if (en_at < 0) en_at = k; end
            @(negedge clk);
        end
        vv = 1'b0;
        total++; if (nsl != 1) begin bad++; $display("FAIL basic_seed_loads got=%0d exp=1", nsl); end
        total++; if (nen != 5) begin bad++; $display("FAIL basic_enable_cycles got=%0d exp=5", nen); end
        total++; if (en_at != sl_at + 1) begin bad++; $display("FAIL basic_enable_rise got=%0d exp=%0d", en_at, sl_at + 1); end
        br(0, 8'h0C, d);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL basic_vec_cnt got=%h exp=5", d); end
        br(0, 8'h04, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL basic_status got=%h exp=b", d); end
    endtask

    task automatic test_busy_writes();
        logic [31:0] d;
        bw(0, 8'h08, 32'd100);
        bw(0, 8'h40, 32'h0);
        bw(0, 8'h00, 32'h1);
        bw(0, 8'h08, 32'd3);
        bw(0, 8'h40, 32'h1234);
        bw(0, 8'h00, 32'h1);
        total++; if (seed_load !== 1'b0) begin bad++; $display("FAIL busy_start_seed_load got=%b exp=0", seed_load); end
        br(0, 8'h04, d);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL busy_status got=%h exp=6", d); end
        br(0, 8'h08, d);
        total++; if (d !== 32'd100) begin bad++; $display("FAIL busy_run_len got=%h exp=64", d); end
        br(0, 8'h40, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL busy_seed0 got=%h exp=0", d); end
        bw(0, 8'h00, 32'h2);
        br(0, 8'h04, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL stop_status got=%h exp=b", d); end
        bw(0, 8'h00, 32'h3);
        br(0, 8'h04, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL done_startstop_status got=%h exp=b", d); end
    endtask

    task automatic test_zero_len();
        logic [31:0] d;
        int nsl = 0, nen = 0;
        bw(0, 8'h08, 32'd0);
        bw(0, 8'h00, 32'h1);
        for (int k = 0; k < 6; k++) begin
            if (seed_load) nsl++;
            if (en) nen++;
            @(negedge clk);
        end
        total++; if (nsl != 1 || nen != 0) begin bad++; $display("FAIL zero_len got=sl%0d/en%0d exp=sl1/en0", nsl, nen); end
        br(0, 8'h04, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL zero_len_status got=%h exp=b", d); end
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        int n = 0;
        logic [31:0] exp_evt [4] = '{32'd10, 32'd0, 32'd10, 32'd0};
        bw(0, 8'h08, 32'd2);
        vv = 1'b1;
        bw(0, 8'h00, 32'h9);
        while (!en && n < 10) begin @(negedge clk); n++; end
        total++; if (!en) begin bad++; $display("FAIL cont_enable_timeout got=0 exp=1"); end
        ev = 4'b0101;
        repeat (10) @(negedge clk);
        ev = 4'b0000; vv = 1'b0;
        br(0, 8'h04, d);
        total++; if (d !== 32'h16) begin bad++; $display("FAIL cont_status_running got=%h exp=16", d); end
        bw(0, 8'h00, 32'h2);
        for (int c = 0; c < 4; c++) begin
            br(0, 8'h80 + 8'(4 * c), d);
            total++; if (d !== exp_evt[c]) begin bad++; $display("FAIL cont_evt%0d got=%0d exp=%0d", c, d, exp_evt[c]); end
        end
        br(0, 8'h04, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL cont_status_done got=%h exp=b", d); end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        bw(0, 8'h00, 32'h4);
        total++; if (ctr_clr !== 1'b1) begin bad++; $display("FAIL clear_pulse_high got=%b exp=1", ctr_clr); end
        @(negedge clk);
        total++; if (ctr_clr !== 1'b0) begin bad++; $display("FAIL clear_pulse_low got=%b exp=0", ctr_clr); end
        br(0, 8'h80, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_evt0 got=%h exp=0", d); end
        br(0, 8'h0C, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_vec got=%h exp=0", d); end
        br(0, 8'h04, d);
        total++; if (d !== 32'hB) begin bad++; $display("FAIL clear_status got=%h exp=b", d); end
    endtask

    task automatic test_random_runs();
        logic [31:0] d, len, mcnt;
        logic [31:0] mseed [4];
        logic [31:0] mevt [4] = '{0, 0, 0, 0};
        logic [3:0]  e;
        logic        v;
        bit          seen, over, fin;
        int          guard, c;
        bw(0, 8'h00, 32'h4);
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 4; i++) begin
                mseed[i] = $urandom;
                bw(0, 8'h40 + 8'(4 * i), mseed[i]);
            end
            total++; if (seeds !== {mseed[3], mseed[2], mseed[1], mseed[0]}) begin bad++; $display("FAIL rnd_seeds_port it=%0d got=%h exp=%h", it, seeds, {mseed[3], mseed[2], mseed[1], mseed[0]}); end
            c = $urandom_range(0, 3);
            br(0, 8'h40 + 8'(4 * c), d);
            total++; if (d !== mseed[c]) begin bad++; $display("FAIL rnd_seed_read ch=%0d got=%h exp=%h", c, d, mseed[c]); end
            len = $urandom_range(1, 12);
            bw(0, 8'h08, len);
            bw(0, 8'h00, 32'h1);
            mcnt = 0; seen = 0; over = 0; fin = 0; guard = 0;
            while (!fin && guard < 300) begin
                v = 1'($urandom); e = 4'($urandom);
                vv = v; ev = e;
                if (en) begin
                    seen = 1;
                    if (mcnt >= len) over = 1;
                    mcnt += 32'(v);
                    for (int k = 0; k < 4; k++) mevt[k] += 32'(e[k]);
                end else if (seen) begin
                    fin = 1;
                end
                @(negedge clk);
                guard++;
            end
            vv = 1'b0; ev = 4'b0;
            total++; if (!fin || over || mcnt != len) begin bad++; $display("FAIL rnd_run_len it=%0d got=%0d exp=%0d fin=%0d over=%0d", it, mcnt, len, fin, over); end
            br(0, 8'h0C, d);
            total++; if (d !== len) begin bad++; $display("FAIL rnd_vec_cnt it=%0d got=%0d exp=%0d", it, d, len); end
            for (int k = 0; k < 4; k++) begin
                br(0, 8'h80 + 8'(4 * k), d);
                total++; if (d !== mevt[k]) begin bad++; $display("FAIL rnd_evt%0d it=%0d got=%0d exp=%0d", k, it, d, mevt[k]); end
            end
            br(0, 8'h04, d);
            total++; if (d !== 32'hB) begin bad++; $display("FAIL rnd_status it=%0d got=%h exp=b", it, d); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        vv2 = 1'b1; ev2 = 2'b11;
        bw(1, 8'h00, 32'h9);
        repeat (300) @(negedge clk);
        br(1, 8'h04, d);
        total++; if (d !== 32'h16) begin bad++; $display("FAIL sat_status_running got=%h exp=16", d); end
        bw(1, 8'h00, 32'h2);
        vv2 = 1'b0; ev2 = 2'b00;
        br(1, 8'h0C, d);
        total++; if (d !== 32'hFF) begin bad++; $display("FAIL sat_vec got=%h exp=ff", d); end
        br(1, 8'h80, d);
        total++; if (d !== 32'hFF) begin bad++; $display("FAIL sat_evt0 got=%h exp=ff", d); end
        br(1, 8'h84, d);
        total++; if (d !== 32'hFF) begin bad++; $display("FAIL sat_evt1 got=%h exp=ff", d); end
        br(1, 8'h88, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL sat_evt_oob got=%h exp=0", d); end
        bw(1, 8'h48, 32'h5A);
        br(1, 8'h48, d);
        total++; if (d !== 32'h0 || seeds2 !== 16'h0) begin bad++; $display("FAIL sat_seed_oob got=%h/%h exp=0/0", d, seeds2); end
        bw(1, 8'h00, 32'h4);
        total++; if (ctr_clr2 !== 1'b1) begin bad++; $display("FAIL sat_clear_pulse got=%b exp=1", ctr_clr2); end
        @(negedge clk);
        total++; if (ctr_clr2 !== 1'b0) begin bad++; $display("FAIL sat_clear_end got=%b exp=0", ctr_clr2); end
        br(1, 8'h0C, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL sat_vec_cleared got=%h exp=0", d); end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        bw(0, 8'h08, 32'd7);
        bw(0, 8'h40, 32'h55);
        br(0, 8'h08, d);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL rw_run_len got=%h exp=7", d); end
        @(negedge clk);
        addr = 8'h40; wdata = 32'hAA; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        total++; if (rdata !== 32'd7) begin bad++; $display("FAIL rw_hold got=%h exp=7", rdata); end
        br(0, 8'h40, d);
        total++; if (d !== 32'h55) begin bad++; $display("FAIL rw_seed0 got=%h exp=55", d); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        int n = 0;
        bw(0, 8'h08, 32'd50);
        bw(0, 8'h00, 32'h1);
        while (!en && n < 10) begin @(negedge clk); n++; end
        total++; if (!en) begin bad++; $display("FAIL midrun_enable_timeout got=0 exp=1"); end
        reset_n = 1'b0;
        #1;
        total++; if ({en, seed_load, ctr_clr} !== 3'b000 || rdata !== 32'h0) begin bad++; $display("FAIL midrun_async got=%b/%h exp=000/0", {en, seed_load, ctr_clr}, rdata); end
        @(negedge clk);
        reset_n = 1'b1;
        br(0, 8'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midrun_status got=%h exp=0", d); end
        br(0, 8'h08, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midrun_run_len got=%h exp=0", d); end
        total++; if (seeds !== 128'h0) begin bad++; $display("FAIL midrun_seeds got=%h exp=0", seeds); end
    endtask

    initial begin
        test_reset();
        test_start_stop_idle();
        test_basic_run();
        test_busy_writes();
        test_zero_len();
        test_continuous();
        test_clear();
        test_random_runs();
        test_saturation();
        test_rw_same_cycle();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
